instr_prefetch_buffer: RTL and testbench

//   Instruction prefetch queue between the 16-bit CPU fetch port and a slow, handshaked instruction memory.

---
 rtl/instr_prefetch_buffer.sv | 176 +++++++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : instr_prefetch_buffer
// Brief    : Sequential instruction prefetch FIFO between CPU fetch port and a
//            handshaked instruction memory; flushes on non-sequential PC.
//            Optional macro PREFETCH_BYPASS_EN forwards MEM_DATA straight to
//            the CPU when the FIFO is empty.
// Revision : 1.0  initial release
// ============================================================================
module instr_prefetch_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          CPU_REQ,
    input  logic [AW-1:0] CPU_PC,
    output logic [DW-1:0] CPU_INST,
    output logic          CPU_VALID,
    output logic          MEM_REQ,
    output logic [AW-1:0] MEM_ADDR,
    input  logic          MEM_ACK,
    input  logic [DW-1:0] MEM_DATA
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [AW-1:0]        r_tag  [DEPTH];
    logic [DW-1:0]        r_data [DEPTH];
    logic [c_PTR_W-1:0]   r_rd;
    logic [c_PTR_W-1:0]   r_wr;
    logic [c_CNT_W-1:0]   r_count;
    logic [AW-1:0]        r_fill;
    logic [AW-1:0]        r_addr;
    logic                 r_pend;
    logic [AW-1:0]        r_pend_pc;
    logic                 r_valid;
    logic [DW-1:0]        r_inst;

    logic                 w_nonempty;
    logic [AW-1:0]        w_expect;
    logic                 w_hit;
    logic                 w_miss;
    logic                 w_bypass;
    logic                 w_fetch_ack;
    logic                 w_push;
    logic                 w_accept;
    logic                 w_issue;
    logic [AW-1:0]        w_fill_nxt;
    logic [c_CNT_W-1:0]   w_count_push;

    assign w_nonempty  = (r_count != '0);
    assign w_expect    = w_nonempty ? r_tag[r_rd] : r_fill;
    assign w_hit       = r_pend && w_nonempty && (r_tag[r_rd] == r_pend_pc);
    assign w_miss      = r_pend && !w_hit && (r_pend_pc != w_expect);
    assign w_fetch_ack = (r_state == S_FETCH) && MEM_ACK;
`ifdef PREFETCH_BYPASS_EN
    assign w_bypass    = r_pend && !w_nonempty && w_fetch_ack && (r_addr == r_pend_pc);
`else
    assign w_bypass    = 1'b0;
`endif
    assign w_push       = w_fetch_ack && !w_miss && !w_bypass;
    assign w_accept     = !r_valid && !r_pend && CPU_REQ;
    assign w_count_push = r_count + {{(c_CNT_W-1){1'b0}}, w_push};
    // A redirect wins over the sequential advance of the fill pointer.
    assign w_fill_nxt   = w_miss      ? r_pend_pc :
                          w_fetch_ack ? r_fill + AW'(1) : r_fill;

    // Next-state: at most one read outstanding, and only when a slot is free.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_miss && (r_count < c_DEPTH_CNT)) begin
                    w_state_nxt = S_FETCH;
                    w_issue     = 1'b1;
                end
            end
            S_FETCH: begin
                if (MEM_ACK) begin
                    if (!w_miss && (w_count_push < c_DEPTH_CNT)) begin
                        w_issue = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_miss) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (MEM_ACK) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_addr <= w_fill_nxt;
            end
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_rd      <= '0;
            r_wr      <= '0;
            r_count   <= '0;
            r_fill    <= '0;
            r_pend    <= 1'b0;
            r_pend_pc <= '0;
            r_valid   <= 1'b0;
            r_inst    <= '0;
        end else begin
            r_fill  <= w_fill_nxt;
            r_valid <= w_hit || w_bypass;
            if (w_miss) begin
                r_rd    <= '0;
                r_wr    <= '0;
                r_count <= '0;
            end else begin
                r_count <= w_count_push - {{(c_CNT_W-1){1'b0}}, w_hit};
                if (w_hit) begin
                    r_rd <= r_rd + c_PTR_W'(1);
                end
                if (w_push) begin
                    r_wr <= r_wr + c_PTR_W'(1);
                end
            end
            if (w_hit) begin
                r_inst <= r_data[r_rd];
            end else if (w_bypass) begin
                r_inst <= MEM_DATA;
            end
            if (w_hit || w_bypass) begin
                r_pend <= 1'b0;
            end else if (w_accept) begin
                r_pend    <= 1'b1;
                r_pend_pc <= CPU_PC;
            end
        end
    end

    always_ff @(posedge CK) begin
        if (w_push) begin
            r_tag[r_wr]  <= r_addr;
            r_data[r_wr] <= MEM_DATA;
        end
    end

    assign CPU_VALID = r_valid;
    assign CPU_INST  = r_inst;
    assign MEM_REQ   = (r_state != S_IDLE);
    assign MEM_ADDR  = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_prefetch_buffer
// Brief    : Directed bench for instr_prefetch_buffer with a 2-cycle memory
//            model and an expected-instruction scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_prefetch_buffer;

    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic        CPU_REQ = 1'b0;
    logic [15:0] CPU_PC = '0;
    logic [15:0] CPU_INST;
    logic        CPU_VALID;
    logic        MEM_REQ;
    logic [15:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [15:0] MEM_DATA;
    logic        m_ack = 1'b0;
    logic        x_ack = 1'b0;
    logic [15:0] m_data = '0;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          first_ack_cyc = 0;
    int          valid_cyc = 0;
    int          wcnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] log_q[$];

`ifdef PREFETCH_BYPASS_EN
    localparam int c_LAT = 1;
`else
    localparam int c_LAT = 2;
`endif

    // Stray acknowledge carries a recognisable junk word.
    assign MEM_ACK  = m_ack | x_ack;
    assign MEM_DATA = x_ack ? 16'hDEAD : m_data;

    instr_prefetch_buffer #(.DEPTH(4), .AW(16), .DW(16)) dut (
        .CK        (CK),
        .RST       (RST),
        .CPU_REQ   (CPU_REQ),
        .CPU_PC    (CPU_PC),
        .CPU_INST  (CPU_INST),
        .CPU_VALID (CPU_VALID),
        .MEM_REQ   (MEM_REQ),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_ACK   (MEM_ACK),
        .MEM_DATA  (MEM_DATA)
    );

    always #5 CK = ~CK;
    always @(posedge CK) cyc <= cyc + 1;

    // Memory: acknowledge two cycles after each request is presented.
    initial begin
        forever begin
            @(negedge CK);
            if (m_ack) begin
                m_ack = 1'b0;
                wcnt  = MEM_REQ ? 1 : 0;
            end else if (MEM_REQ) begin
                if (wcnt >= 1) begin
                    m_ack  = 1'b1;
                    m_data = MEM_ADDR ^ 16'hA5A5;
                    if (log_q.size() == 0) first_ack_cyc = cyc;
                    log_q.push_back(MEM_ADDR);
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge CK);
            if (CPU_VALID) begin
                valid_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_cpu_valid actual=%h required=none", CPU_INST);
                end else begin
                    e = exp_q.pop_front();
                    if (CPU_INST !== e) begin
                        failures++;
                        $display("FAIL cpu_inst actual=%h required=%h", CPU_INST, e);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < log_q.size()) return {16'h0, log_q[i]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic fetch(input logic [15:0] pc, input logic [15:0] exp, input bit now);
        int n;
        if (!now) begin
            @(negedge CK);
            while (CPU_VALID) @(negedge CK);
        end
        exp_q.push_back(exp);
        CPU_PC  = pc;
        CPU_REQ = 1'b1;
        @(posedge CK);
        #1 CPU_REQ = 1'b0;
        n = 0;
        while (!CPU_VALID && n < 60) begin
            @(negedge CK);
            n++;
        end
        if (!CPU_VALID) begin
            checks++;
            failures++;
            $display("FAIL fetch_timeout pc=%h actual=none required=%h", pc, exp);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge CK);
        RST = 1'b1;
        repeat (n) @(negedge CK);
        log_q.delete();
        RST = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_cpu_valid"}, {31'h0, CPU_VALID}, 32'h0);
        chk({tag, "_cpu_inst"},  {16'h0, CPU_INST},  32'h0);
        chk({tag, "_mem_req"},   {31'h0, MEM_REQ},   32'h0);
        chk({tag, "_mem_addr"},  {16'h0, MEM_ADDR},  32'h0);
    endtask

    initial begin
        int n;
        // 1: reset state, then sequential fetch from 0.
        repeat (3) @(negedge CK);
        chk_zero_outputs("reset");
        log_q.delete();
        RST = 1'b0;
        fetch(16'h0000, 16'hA5A5, 1'b0);
        fetch(16'h0001, 16'hA5A4, 1'b0);
        fetch(16'h0002, 16'hA5A7, 1'b0);
        fetch(16'h0003, 16'hA5A6, 1'b0);
        for (int i = 0; i < 4; i++) chk("t1_mem_addr_order", log_at(i), i);

        // 2: idle CPU fills exactly DEPTH words; stray ACK ignored.
        do_reset(2);
        repeat (30) @(negedge CK);
        chk("t2_req_count", log_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("t2_mem_addr", log_at(i), i);
        chk("t2_mem_req_idle", {31'h0, MEM_REQ}, 32'h0);
        x_ack = 1'b1;
        @(negedge CK);
        x_ack = 1'b0;
        repeat (3) @(negedge CK);
        chk("t2_stray_ack_req", {31'h0, MEM_REQ}, 32'h0);
        fetch(16'h0000, 16'hA5A5, 1'b0);
        n = 0;
        while (log_q.size() < 5 && n < 20) begin
            @(negedge CK);
            n++;
        end
        chk("t2_refill_addr", log_at(4), 32'h4);

        // 3: jump while the FIFO is full.
        do_reset(2);
        repeat (20) @(negedge CK);
        log_q.delete();
        fetch(16'h0040, 16'hA5E5, 1'b0);
        chk("t3_flush_addr", log_at(0), 32'h40);
        fetch(16'h0041, 16'hA5E4, 1'b0);

        // 4: jump while the read of address 2 is outstanding.
        do_reset(2);
        n = 0;
        while (!(MEM_REQ && MEM_ADDR == 16'h0002) && n < 40) begin
            @(negedge CK);
            n++;
        end
        chk("t4_reach_addr2", {31'h0, (MEM_REQ && MEM_ADDR == 16'h0002)}, 32'h1);
        log_q.delete();
        fetch(16'h0040, 16'hA5E5, 1'b1);
        chk("t4_stale_addr", log_at(0), 32'h2);
        chk("t4_after_drop_addr", log_at(1), 32'h40);

        // 5: address wrap.
        fetch(16'hFFFE, 16'h5A5B, 1'b0);
        fetch(16'hFFFF, 16'h5A5A, 1'b0);
        fetch(16'h0000, 16'hA5A5, 1'b0);

        // 6: reset during a transfer, stray ACK in reset, restart at 0.
        n = 0;
        while (!MEM_REQ && n < 40) begin
            @(negedge CK);
            n++;
        end
        chk("t6_req_active", {31'h0, MEM_REQ}, 32'h1);
        RST = 1'b1;
        @(negedge CK);
        chk_zero_outputs("t6_reset");
        x_ack = 1'b1;
        @(negedge CK);
        x_ack = 1'b0;
        @(negedge CK);
        log_q.delete();
        RST = 1'b0;
        fetch(16'h0000, 16'hA5A5, 1'b1);
        @(negedge CK);
        chk("t6_restart_addr", log_at(0), 32'h0);
        chk("t6_ack_to_valid", valid_cyc - first_ack_cyc, c_LAT);

        repeat (5) @(negedge CK);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
